// File: rtl/key_filter_pkg.sv
// Shared definitions for the key_filter debouncer: the per-channel FSM
// state encoding and the widths of the debounce and long-press counters.
package key_filter_pkg;

    // HELD and RFILT both have bit 1 set, so that bit is the debounced level
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PFILT = 2'd1,
        HELD  = 2'd2,
        RFILT = 2'd3
    } key_fsm_state_t;

    localparam int DEB_CNT_W  = 10;
    localparam int LONG_CNT_W = 11;

endpackage

// File: rtl/key_filter_if.sv
// Bundle of the key_filter timebase strobe, raw key pins and per-key
// event outputs. The slave side is the debouncer; the master side is
// whoever supplies the keys and consumes the events.
interface key_filter_if #(
    parameter int KEY_NUM = 4
);
    logic               tick_1ms;
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] key_press;
    logic [KEY_NUM-1:0] key_release;
    logic [KEY_NUM-1:0] key_long;

    modport master (
        output tick_1ms,
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  tick_1ms,
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_fsm.sv
// One key channel: 2-flop synchroniser, debounce FSM, debounce counter and
// (when KEY_LONG_PRESS_EN is defined) the long-press counter. All outputs
// come straight from flops.
module key_fsm
    import key_filter_pkg::*;
#(
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic                 RELEASED_LVL = KEY_ACTIVE_LOW;
    localparam logic [DEB_CNT_W-1:0] DEB_LAST     = DEB_CNT_W'(DEBOUNCE_MS - 1);

    logic                 sync_q1;
    logic                 sync_q2;
    logic                 raw_pressed;
    key_fsm_state_t       state_q;
    key_fsm_state_t       state_d;
    logic [DEB_CNT_W-1:0] deb_cnt_q;
    logic [DEB_CNT_W-1:0] deb_cnt_d;
    logic                 press_q;
    logic                 press_d;
    logic                 release_q;
    logic                 release_d;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [LONG_CNT_W-1:0] LONG_LAST = LONG_CNT_W'(LONG_MS - 1);
    localparam logic [LONG_CNT_W-1:0] LONG_SAT  = LONG_CNT_W'(LONG_MS);

    logic [LONG_CNT_W-1:0] long_cnt_q;
    logic [LONG_CNT_W-1:0] long_cnt_d;
    logic                  long_q;
    logic                  long_d;
`endif

    // Synchroniser starts at the released level so reset release never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= RELEASED_LVL;
            sync_q2 <= RELEASED_LVL;
        end else begin
            sync_q1 <= key_in;
            sync_q2 <= sync_q1;
        end
    end

    assign raw_pressed = sync_q2 ^ KEY_ACTIVE_LOW;

    // Next-state logic: a raw change always beats a tick arriving in the same cycle
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (raw_pressed) begin
                    state_d   = PFILT;
                    deb_cnt_d = '0;
                end
            end
            PFILT: begin
                if (!raw_pressed) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (tick_1ms) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d    = HELD;
                        deb_cnt_d  = '0;
                        press_d    = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                        long_cnt_d = '0;
`endif
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            end
            HELD: begin
                if (!raw_pressed) begin
                    state_d   = RFILT;
                    deb_cnt_d = '0;
                end
`ifdef KEY_LONG_PRESS_EN
                else if (tick_1ms && (long_cnt_q != LONG_SAT)) begin
                    long_cnt_d = long_cnt_q + 1'b1;
                    long_d     = (long_cnt_q == LONG_LAST);
                end
`endif
            end
            RFILT: begin
                if (raw_pressed) begin
                    state_d = HELD;
                end else if (tick_1ms) begin
                    if (deb_cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        deb_cnt_d = '0;
                        release_d = 1'b1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // State, counters and event pulses; reset drops everything to IDLE with no pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_q <= '0;
            long_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
`endif
        end
    end

    assign key_state   = state_q[1];
    assign key_press   = press_q;
    assign key_release = release_q;
`ifdef KEY_LONG_PRESS_EN
    assign key_long    = long_q;
`else
    assign key_long    = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// Multi-channel push-button debouncer: KEY_NUM independent key_fsm
// channels sharing the 1 ms tick. Long-press pulses are only generated
// when KEY_LONG_PRESS_EN is defined; otherwise key_long stays 0.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int KEY_NUM        = 4,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    key_filter_if.slave  bus
);

    logic [KEY_NUM-1:0] state_vec;
    logic [KEY_NUM-1:0] press_vec;
    logic [KEY_NUM-1:0] release_vec;
    logic [KEY_NUM-1:0] long_vec;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_fsm #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .LONG_MS        (LONG_MS),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_key_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick_1ms    (bus.tick_1ms),
            .key_in      (bus.key_in[i]),
            .key_state   (state_vec[i]),
            .key_press   (press_vec[i]),
            .key_release (release_vec[i]),
            .key_long    (long_vec[i])
        );
    end

    assign bus.key_state   = state_vec;
    assign bus.key_press   = press_vec;
    assign bus.key_release = release_vec;
    assign bus.key_long    = long_vec;

endmodule

// File: tb/tb_key_filter.sv
// Testbench for key_filter. Two instances share the same stimulus: the main
// one (DEBOUNCE_MS=4, LONG_MS=10) and a corner one (DEBOUNCE_MS=1, LONG_MS=3).
// Both are compared every cycle against a level/streak reference model, and
// the main one is also checked against hand-computed pulse counts.
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_filter;

    localparam int KEY_NUM     = 4;
    localparam int DEB0        = 4;
    localparam int LONG0       = 10;
    localparam int DEB1        = 1;
    localparam int LONG1       = 3;
    localparam int TICK_PERIOD = 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] keys;
        int         cycles;
        logic [3:0] exp_state;
        logic [3:0] exp_press;
        logic [3:0] exp_rel;
        logic [3:0] exp_long;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1ms = 1'b0;
    logic [3:0] key_in;
    int         tick_phase = 0;

    int n_vec = 0;
    int n_err = 0;

    key_filter_if #(.KEY_NUM(KEY_NUM)) bus0 ();
    key_filter_if #(.KEY_NUM(KEY_NUM)) bus1 ();

    assign bus0.tick_1ms = tick_1ms;
    assign bus0.key_in   = key_in;
    assign bus1.tick_1ms = tick_1ms;
    assign bus1.key_in   = key_in;

    key_filter #(
        .KEY_NUM(KEY_NUM), .DEBOUNCE_MS(DEB0), .LONG_MS(LONG0), .KEY_ACTIVE_LOW(1'b1)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    key_filter #(
        .KEY_NUM(KEY_NUM), .DEBOUNCE_MS(DEB1), .LONG_MS(LONG1), .KEY_ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic [15:0] act0;
    logic [15:0] act1;
    assign act0 = {bus0.key_state, bus0.key_press, bus0.key_release, bus0.key_long};
    assign act1 = {bus1.key_state, bus1.key_press, bus1.key_release, bus1.key_long};

    // Free-running clock
    always #5 clk = ~clk;

    // 1 ms strobe every TICK_PERIOD clocks, driven away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            tick_phase = 0;
            tick_1ms   = 1'b0;
        end else begin
            tick_1ms   = (tick_phase == TICK_PERIOD - 1);
            tick_phase = (tick_phase == TICK_PERIOD - 1) ? 0 : tick_phase + 1;
        end
    end

    // Reference model: debounced level per channel, whether the synchronised
    // key has disagreed with it since the previous cycle, ticks seen during
    // that disagreement, and ticks held since the accepted press.
    logic [3:0] m_s1;
    logic [3:0] m_s2;
    bit         m_lvl  [2][KEY_NUM];
    bit         m_run  [2][KEY_NUM];
    int         m_deb  [2][KEY_NUM];
    int         m_hold [2][KEY_NUM];
    logic [3:0] e_state [2];
    logic [3:0] e_press [2];
    logic [3:0] e_rel   [2];
    logic [3:0] e_long  [2];

    function automatic int deb_of(int c);
        return (c == 0) ? DEB0 : DEB1;
    endfunction

    function automatic int long_of(int c);
        return (c == 0) ? LONG0 : LONG1;
    endfunction

    // Model advances on the same edge as the DUTs and resets asynchronously with them
    always @(posedge clk or negedge rst_n) begin
        bit raw, lvl, run, p, r, l;
        int deb, hold;
        if (!rst_n) begin
            m_s1 <= '0;
            m_s2 <= '0;
            for (int c = 0; c < 2; c++) begin
                e_state[c] <= '0;
                e_press[c] <= '0;
                e_rel[c]   <= '0;
                e_long[c]  <= '0;
                for (int k = 0; k < KEY_NUM; k++) begin
                    m_lvl[c][k]  <= 1'b0;
                    m_run[c][k]  <= 1'b0;
                    m_deb[c][k]  <= 0;
                    m_hold[c][k] <= 0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < KEY_NUM; k++) begin
                    raw  = m_s2[k];
                    lvl  = m_lvl[c][k];
                    run  = m_run[c][k];
                    deb  = m_deb[c][k];
                    hold = m_hold[c][k];
                    p = 1'b0;
                    r = 1'b0;
                    l = 1'b0;
                    if (raw != lvl) begin
                        if (!run) begin
                            run = 1'b1;
                            deb = 0;
                        end else if (tick_1ms) begin
                            deb = deb + 1;
                            if (deb == deb_of(c)) begin
                                lvl = raw;
                                run = 1'b0;
                                deb = 0;
                                if (raw) begin
                                    p    = 1'b1;
                                    hold = 0;
                                end else begin
                                    r = 1'b1;
                                end
                            end
                        end
                    end else begin
                        if (!run && lvl && tick_1ms && hold < long_of(c)) begin
                            hold = hold + 1;
                            l    = LONG_EN && (hold == long_of(c));
                        end
                        run = 1'b0;
                        deb = 0;
                    end
                    m_lvl[c][k]  <= lvl;
                    m_run[c][k]  <= run;
                    m_deb[c][k]  <= deb;
                    m_hold[c][k] <= hold;
                    e_state[c][k] <= lvl;
                    e_press[c][k] <= p;
                    e_rel[c][k]   <= r;
                    e_long[c][k]  <= l;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= ~key_in;
        end
    end

    function automatic logic [15:0] exp_of(int c);
        return {e_state[c], e_press[c], e_rel[c], e_long[c]};
    endfunction

    // Pulse bookkeeping for the main instance
    int press_tot [KEY_NUM];
    int rel_tot   [KEY_NUM];
    int long_tot  [KEY_NUM];
    int base_p    [KEY_NUM];
    int base_r    [KEY_NUM];
    int base_l    [KEY_NUM];
    int cyc        = 0;
    int press_cyc2 = -1;
    int long_cyc2  = -1;

    task automatic checkOutput(input string name, input int actual, input int lo, input int hi);
        n_vec++;
        if (actual < lo || actual > hi) begin
            n_err++;
            if (lo == hi)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, lo);
            else
                $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                checkOutput("model cfg0", int'(act0), int'(exp_of(0)), int'(exp_of(0)));
                checkOutput("model cfg1", int'(act1), int'(exp_of(1)), int'(exp_of(1)));
                for (int k = 0; k < KEY_NUM; k++) begin
                    if (bus0.key_press[k])   press_tot[k]++;
                    if (bus0.key_release[k]) rel_tot[k]++;
                    if (bus0.key_long[k])    long_tot[k]++;
                end
                if (bus0.key_press[2]) press_cyc2 = cyc;
                if (bus0.key_long[2])  long_cyc2  = cyc;
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] keys, input int cycles);
        key_in = keys;
        step(cycles);
    endtask

    task automatic snapshot();
        for (int k = 0; k < KEY_NUM; k++) begin
            base_p[k] = press_tot[k];
            base_r[k] = rel_tot[k];
            base_l[k] = long_tot[k];
        end
    endtask

    function automatic logic [7:0] expand(logic [3:0] m);
        logic [7:0] v;
        for (int k = 0; k < 4; k++) v[2*k +: 2] = m[k] ? 2'd1 : 2'd0;
        return v;
    endfunction

    function automatic logic [1:0] clip(int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // Watchdog: the run must never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    vec_t       tbl [9];
    logic [7:0] ap, ar, al;
    int         lat;
    bit         found;

    // Main sequence: reset, vector table, hand-written corner cases, random phase
    initial begin
        tbl[0] = '{4'hF, 200, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{4'hB, 400, 4'h4, 4'h4, 4'h0, (LONG_EN ? 4'h4 : 4'h0)};
        tbl[2] = '{4'hB, 400, 4'h4, 4'h0, 4'h0, 4'h0};
        tbl[3] = '{4'hF, 200, 4'h0, 4'h0, 4'h4, 4'h0};
        tbl[4] = '{4'h7, 200, 4'h8, 4'h8, 4'h0, 4'h0};
        tbl[5] = '{4'hF,  40, 4'h8, 4'h0, 4'h0, 4'h0};
        tbl[6] = '{4'h7, 160, 4'h8, 4'h0, 4'h0, (LONG_EN ? 4'h8 : 4'h0)};
        tbl[7] = '{4'hF, 200, 4'h0, 4'h0, 4'h8, 4'h0};
        tbl[8] = '{4'h6, 200, 4'h9, 4'h9, 4'h0, 4'h0};

        key_in = 4'hF;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset cfg0", int'(act0), 0, 0);
        checkOutput("reset cfg1", int'(act1), 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            snapshot();
            applyStimulus(tbl[i].keys, tbl[i].cycles);
            for (int k = 0; k < KEY_NUM; k++) begin
                ap[2*k +: 2] = clip(press_tot[k] - base_p[k]);
                ar[2*k +: 2] = clip(rel_tot[k]   - base_r[k]);
                al[2*k +: 2] = clip(long_tot[k]  - base_l[k]);
            end
            checkOutput($sformatf("vec%0d key_state", i), int'(bus0.key_state),
                        int'(tbl[i].exp_state), int'(tbl[i].exp_state));
            checkOutput($sformatf("vec%0d press count", i), int'(ap),
                        int'(expand(tbl[i].exp_press)), int'(expand(tbl[i].exp_press)));
            checkOutput($sformatf("vec%0d release count", i), int'(ar),
                        int'(expand(tbl[i].exp_rel)), int'(expand(tbl[i].exp_rel)));
            checkOutput($sformatf("vec%0d long count", i), int'(al),
                        int'(expand(tbl[i].exp_long)), int'(expand(tbl[i].exp_long)));
        end

`ifdef KEY_LONG_PRESS_EN
        checkOutput("key2 press-to-long clk", long_cyc2 - press_cyc2, 200, 200);
`else
        checkOutput("key_long pulse total",
                    long_tot[0] + long_tot[1] + long_tot[2] + long_tot[3], 0, 0);
`endif

        // Keys 0 and 3 are HELD: assert reset between clock edges
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset cfg0", int'(act0), 0, 0);
        checkOutput("async reset cfg1", int'(act1), 0, 0);
        key_in = 4'hF;
        repeat (4) @(negedge clk);
        checkOutput("held in reset cfg0", int'(act0), 0, 0);
        snapshot();
        rst_n = 1'b1;
        step(100);
        checkOutput("pulses after reset release",
                    (rel_tot[0] - base_r[0]) + (rel_tot[3] - base_r[3]) +
                    (press_tot[0] - base_p[0]) + (press_tot[3] - base_p[3]), 0, 0);

        // Key0 press latency from the pin edge
        snapshot();
        key_in = 4'hE;
        lat    = 0;
        found  = 1'b0;
        while (!found && lat < 300) begin
            step(1);
            lat++;
            if (bus0.key_press[0]) found = 1'b1;
        end
        checkOutput("key0 press latency clk", found ? lat : -1, 62, 84);
        if (lat < 200) step(200 - lat);
        checkOutput("key0 state held", int'(bus0.key_state), 1, 1);
        checkOutput("key0 press count", press_tot[0] - base_p[0], 1, 1);
        applyStimulus(4'hF, 200);
        checkOutput("key0 state released", int'(bus0.key_state), 0, 0);
        checkOutput("key0 release count", rel_tot[0] - base_r[0], 1, 1);

        // Key1 bounces every 30 clk, then settles pressed
        snapshot();
        for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 4'hD : 4'hF, 30);
        checkOutput("key1 press during bounce", press_tot[1] - base_p[1], 0, 0);
        applyStimulus(4'hD, 200);
        checkOutput("key1 press after settle", press_tot[1] - base_p[1], 1, 1);
        checkOutput("key1 state after settle", int'(bus0.key_state), 2, 2);
        applyStimulus(4'hF, 200);

        // Random key patterns with random hold times, model-checked every cycle
        for (int s = 0; s < 60; s++) applyStimulus(4'($urandom), $urandom_range(150, 1));
        applyStimulus(4'hF, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
